pipelined_rca: RTL
==================

PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4: number of carry-pipeline stages; WIDTH SHALL be an integer multiple of STAGES, and chunk width C = WIDTH/STAGES.
REQ-003 clk  input  1  rising-edge clock; the only clock in the block.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in0  input  WIDTH  operand A.
REQ-006 in1  input  WIDTH  operand B.
REQ-007 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-008 sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-009 in_valid  input  1  the operand set on in0/in1/cin/sub is valid this cycle.
REQ-010 in_ready  output  1  the block can accept an operand set this cycle.
REQ-011 out  output  WIDTH  result.
REQ-012 cout  output  1  carry out of the MSB.
REQ-013 ovf  output  1  two's-complement signed overflow.
REQ-014 out_valid  output  1  out/cout/ovf are valid this cycle.
REQ-015 out_ready  input  1  the downstream consumer accepts the result this cycle.

Function
REQ-016 An operand set SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-017 A result SHALL be consumed on a rising edge where out_valid && out_ready.
REQ-018 Add mode (sub=0): {cout,out} SHALL equal in0 + in1 + cin, computed as a (WIDTH+1)-bit sum.
REQ-019 Subtract mode (sub=1): the block SHALL compute in0 + ~in1 + !cin, giving out = in0 - in1 - cin mod 2^WIDTH; cout=1 SHALL mean no borrow.
REQ-020 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB for the effective addition.
REQ-021 Stage k (k = 0..STAGES-1) SHALL add chunk bits [k*C +: C] using the registered carry from stage k-1; stage 0 SHALL use the effective carry-in.
REQ-022 Operand chunks for later stages SHALL be skew-delayed, and result chunks from earlier stages SHALL be deskew-delayed, so that all WIDTH result bits, cout and ovf of one operand set appear together.
REQ-023 Latency: with no stall, the results for a set accepted at edge N SHALL present out_valid=1 after edge N+STAGES.
REQ-024 Throughput: with no stall, the block SHALL accept one operand set per cycle.
REQ-025 The block SHALL keep a valid bit per stage; results SHALL emerge in acceptance order with no loss and no duplication.
REQ-026 Stall condition: out_valid && !out_ready SHALL freeze every stage register and every valid bit.
REQ-027 During a stall, in_ready SHALL be 0 and out/cout/ovf SHALL hold stable.
REQ-028 in_ready SHALL equal !(out_valid && !out_ready) and SHALL be a combinational function of registered state and out_ready only.
REQ-029 A pipeline bubble (in_valid=0 while in_ready=1) SHALL propagate as valid=0 through the stages; out_valid=0 cycles SHALL occur at the corresponding output slots.
REQ-030 When out_valid=0, out/cout/ovf values are don't-care for the consumer, but the block SHALL NOT produce X on them after reset.
REQ-031 STAGES=1 SHALL degenerate to one registered ripple-carry adder with latency 1.

Reset
REQ-032 When rst=1 at an edge, all stage valid bits SHALL clear and out_valid, out, cout and ovf SHALL become 0.
REQ-033 While rst=1, in_ready SHALL be 1 after the first reset edge, and any operand offered SHALL be discarded.
REQ-034 Reset asserted mid-operation SHALL drop all in-flight sets; none SHALL emerge after rst deasserts.
REQ-035 The first operand set accepted after rst deasserts SHALL follow REQ-023 latency exactly.

Verification
REQ-036 Bench with WIDTH=16, STAGES=4: add 0xFFFF + 0x0001, cin=0 -> 4 cycles later out=0x0000, cout=1, ovf=0, out_valid=1.
REQ-037 Subtract 0x8000 - 0x0001, cin=0 -> out=0x7FFF, cout=1, ovf=1. Subtract 0x0000 - 0x0001 -> out=0xFFFF, cout=0, ovf=0.
REQ-038 Stream 8 back-to-back sets with out_ready=1 -> 8 consecutive out_valid cycles starting at edge N+4, results in order and matching a reference model.
REQ-039 Pipeline full, then out_ready=0 for 3 cycles -> in_ready=0 and out stable for those 3 cycles; after release, every result appears exactly once, in order.
REQ-040 3 sets in flight, then rst=1 for 1 cycle -> out_valid=0 on the next cycle, and no stale result appears afterwards.
REQ-041 WIDTH=4, STAGES=2, random out_ready: all 256 in0/in1 pairs x cin x sub -> every result matches the reference model.

Source files
------------

// File: rtl/pipelined_rca_if.sv
// Operand/result handshake bundle for the pipelined ripple-carry adder.
// The master side offers operands and consumes results; the slave side is the adder.
interface pipelined_rca_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             cin;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in0, in1, cin, sub, in_valid, out_ready,
        input  in_ready, out, cout, ovf, out_valid
    );

    modport slave (
        input  in0, in1, cin, sub, in_valid, out_ready,
        output in_ready, out, cout, ovf, out_valid
    );
endinterface

// File: rtl/pipelined_rca.sv
// Ripple-carry adder/subtractor split into STAGES carry-pipelined chunks, with
// operand skew and result deskew so each operand set leaves as one aligned result.
module pipelined_rca #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic             clk,
    input logic             rst,
    pipelined_rca_if.slave  bus
);
    localparam int C = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_rca: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // Level 0 holds the captured operands with the subtract inversion already
    // applied; level k+1 holds the operands after chunk k has been summed in place.
    logic [STAGES:0]  valid_q;
    logic [STAGES:0]  carry_q;
    logic [WIDTH-1:0] acc_q [STAGES+1];
    logic [WIDTH-1:0] opb_q [STAGES+1];
    logic             ovf_q;

    logic [C:0]       chunk_sum [STAGES];
    logic [WIDTH-1:0] acc_d     [STAGES];
    logic             msb_carry;
    logic             stall;

    always_comb begin
        stall = valid_q[STAGES] && !bus.out_ready;
    end

    assign bus.in_ready  = !stall;
    assign bus.out       = acc_q[STAGES];
    assign bus.cout      = carry_q[STAGES];
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = valid_q[STAGES];

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            chunk_sum[k] = {1'b0, acc_q[k][k*C +: C]} + {1'b0, opb_q[k][k*C +: C]}
                         + {{C{1'b0}}, carry_q[k]};
            acc_d[k] = acc_q[k];
            acc_d[k][k*C +: C] = chunk_sum[k][C-1:0];
        end
        // Sum bit equals a ^ b ^ carry-in, so the carry into the MSB falls out directly.
        msb_carry = acc_q[STAGES-1][WIDTH-1] ^ opb_q[STAGES-1][WIDTH-1]
                  ^ chunk_sum[STAGES-1][C-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k <= STAGES; k++) begin
                acc_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else if (!stall) begin
            valid_q <= {valid_q[STAGES-1:0], bus.in_valid};
            if (bus.in_valid) begin
                acc_q[0]   <= bus.in0;
                opb_q[0]   <= bus.sub ? ~bus.in1 : bus.in1;
                carry_q[0] <= bus.cin ^ bus.sub;
            end
            // Data only moves with a valid set, so bubbles never disturb held values.
            for (int k = 0; k < STAGES; k++) begin
                if (valid_q[k]) begin
                    acc_q[k+1]   <= acc_d[k];
                    opb_q[k+1]   <= opb_q[k];
                    carry_q[k+1] <= chunk_sum[k][C];
                end
            end
            if (valid_q[STAGES-1]) begin
                ovf_q <= msb_carry ^ chunk_sum[STAGES-1][C];
            end
        end
    end
endmodule
